// File: rtl/rotate_sweep_ctrl_if.sv
// rtl/rotate_sweep_ctrl_if.sv - request, rotator and result signals of rotate_sweep_ctrl (out_parity under ROT_SWEEP_PARITY_EN)
interface rotate_sweep_ctrl_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [2:0] in_first;
  logic [3:0] in_count;
  logic [7:0] shf_d;
  logic [2:0] shf_s;
  logic [7:0] shf_q;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [2:0] out_amt;
  logic       out_last;
`ifdef ROT_SWEEP_PARITY_EN
  logic       out_parity;

  modport slave (
    input  in_valid, in_data, in_first, in_count, shf_q, out_ready,
    output in_ready, shf_d, shf_s, out_valid, out_data, out_amt, out_last, out_parity
  );
  modport master (
    output in_valid, in_data, in_first, in_count, shf_q, out_ready,
    input  in_ready, shf_d, shf_s, out_valid, out_data, out_amt, out_last, out_parity
  );
`else
  modport slave (
    input  in_valid, in_data, in_first, in_count, shf_q, out_ready,
    output in_ready, shf_d, shf_s, out_valid, out_data, out_amt, out_last
  );
  modport master (
    output in_valid, in_data, in_first, in_count, shf_q, out_ready,
    input  in_ready, shf_d, shf_s, out_valid, out_data, out_amt, out_last
  );
`endif
endinterface

// File: rtl/rotate_sweep_ctrl.sv
// rtl/rotate_sweep_ctrl.sv - sweeps an external 8-bit right rotator over consecutive amounts
// Optional registered result parity on out_parity when ROT_SWEEP_PARITY_EN is defined.
module rotate_sweep_ctrl (
  input  logic                 clk,
  input  logic                 reset,
  rotate_sweep_ctrl_if.slave   bus,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;

  state_t     state;
  state_t     state_next;
  logic [7:0] data_r;
  logic [2:0] amt_r;
  logic [3:0] rem_r;
  logic [7:0] out_data_r;
  logic [2:0] out_amt_r;
  logic       out_last_r;
  logic       load;
  logic       capture;
  logic       advance;
  logic [3:0] count_norm;

  // Zero and anything above 8 both mean a full sweep of all amounts.
  assign count_norm = ((bus.in_count == 4'd0) || (bus.in_count > 4'd8)) ? 4'd8 : bus.in_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next   = state;
    bus.in_ready = 1'b0;
    bus.out_valid = 1'b0;
    load         = 1'b0;
    capture      = 1'b0;
    advance      = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          load       = 1'b1;
          state_next = CALC;
        end
      end
      CALC: begin
        capture    = 1'b1;
        state_next = OUT;
      end
      OUT: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          if (out_last_r) begin
            state_next = IDLE;
          end else begin
            advance    = 1'b1;
            state_next = CALC;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_r     <= 8'd0;
      amt_r      <= 3'd0;
      rem_r      <= 4'd0;
      out_data_r <= 8'd0;
      out_amt_r  <= 3'd0;
      out_last_r <= 1'b0;
    end else begin
      if (load) begin
        data_r <= bus.in_data;
        amt_r  <= bus.in_first;
        rem_r  <= count_norm;
      end
      if (capture) begin
        out_data_r <= bus.shf_q;
        out_amt_r  <= amt_r;
        out_last_r <= (rem_r == 4'd1);
      end
      if (advance) begin
        amt_r <= amt_r + 3'd1;
        rem_r <= rem_r - 4'd1;
      end
    end
  end

`ifdef ROT_SWEEP_PARITY_EN
  logic out_parity_r;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        out_parity_r <= 1'b0;
    else if (capture) out_parity_r <= ^bus.shf_q;
  end

  assign bus.out_parity = out_parity_r;
`endif

  assign bus.shf_d    = data_r;
  assign bus.shf_s    = amt_r;
  assign bus.out_data = out_data_r;
  assign bus.out_amt  = out_amt_r;
  assign bus.out_last = out_last_r;
  assign busy         = (state != IDLE);

endmodule

// File: tb/tb_rotate_sweep_ctrl.sv
// tb/tb_rotate_sweep_ctrl.sv - directed scoreboard bench for rotate_sweep_ctrl with a behavioural rotator
module tb_rotate_sweep_ctrl;

  logic clk;
  logic reset;
  logic busy;

  rotate_sweep_ctrl_if ifc ();

  rotate_sweep_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave),
    .busy  (busy)
  );

  typedef struct packed {
    logic [7:0] data;
    logic [2:0] amt;
    logic       last;
  } exp_t;

  exp_t sb[$];
  int   n_cmp;
  int   n_err;

  function automatic logic [7:0] rot(input logic [7:0] d, input logic [2:0] s);
    logic [15:0] t;
    t = {d, d} >> s;
    return t[7:0];
  endfunction

  // External rotator: Q[i] = D[(i+s) mod 8]
  assign ifc.shf_q = rot(ifc.shf_d, ifc.shf_s);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_req(input logic [7:0] d, input logic [2:0] f, input logic [3:0] c);
    int   n;
    exp_t e;
    logic [2:0] a;
    n = ((c == 4'd0) || (c > 4'd8)) ? 8 : int'(c);
    a = f;
    for (int k = 0; k < n; k++) begin
      e.data = rot(d, a);
      e.amt  = a;
      e.last = (k == n - 1);
      sb.push_back(e);
      a = a + 3'd1;
    end
  endtask

  task automatic send(input logic [7:0] d, input logic [2:0] f, input logic [3:0] c);
    int n;
    ifc.in_valid = 1'b1;
    ifc.in_data  = d;
    ifc.in_first = f;
    ifc.in_count = c;
    n = 0;
    while (!ifc.in_ready && n < 40) begin
      step();
      n++;
    end
    check("in_ready_timeout", {7'd0, ifc.in_ready}, 8'd1);
    step();
    ifc.in_valid = 1'b0;
    push_req(d, f, c);
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!ifc.out_valid && n < 20) begin
      step();
      n++;
    end
    check("out_valid_timeout", {7'd0, ifc.out_valid}, 8'd1);
  endtask

  task automatic check_head(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 8'd1, 8'd0);
    end else begin
      e = sb[0];
      check({tag, "_data"}, ifc.out_data, e.data);
      check({tag, "_amt"}, {5'd0, ifc.out_amt}, {5'd0, e.amt});
      check({tag, "_last"}, {7'd0, ifc.out_last}, {7'd0, e.last});
`ifdef ROT_SWEEP_PARITY_EN
      check({tag, "_parity"}, {7'd0, ifc.out_parity}, {7'd0, ^e.data});
`endif
    end
  endtask

  task automatic collect(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      wait_valid();
      check_head(tag);
      if (sb.size() != 0) void'(sb.pop_front());
      ifc.out_ready = 1'b1;
      step();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, {7'd0, ifc.in_ready}, 8'd1);
    check({tag, "_out_valid"}, {7'd0, ifc.out_valid}, 8'd0);
    check({tag, "_out_data"}, ifc.out_data, 8'd0);
    check({tag, "_out_amt"}, {5'd0, ifc.out_amt}, 8'd0);
    check({tag, "_out_last"}, {7'd0, ifc.out_last}, 8'd0);
    check({tag, "_busy"}, {7'd0, busy}, 8'd0);
    check({tag, "_shf_d"}, ifc.shf_d, 8'd0);
    check({tag, "_shf_s"}, {5'd0, ifc.shf_s}, 8'd0);
`ifdef ROT_SWEEP_PARITY_EN
    check({tag, "_out_parity"}, {7'd0, ifc.out_parity}, 8'd0);
`endif
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset         = 1'b1;
    ifc.in_valid  = 1'b0;
    ifc.in_data   = 8'd0;
    ifc.in_first  = 3'd0;
    ifc.in_count  = 4'd0;
    ifc.out_ready = 1'b1;
    step();
    step();
    check_reset_outputs("rst");
    reset = 1'b0;
    step();
    check_reset_outputs("idle");

    // Basic three-step sweep, first result two cycles after acceptance
    send(8'h81, 3'd1, 4'd3);
    check("calc_busy", {7'd0, busy}, 8'd1);
    check("calc_no_valid", {7'd0, ifc.out_valid}, 8'd0);
    step();
    check("first_latency", {7'd0, ifc.out_valid}, 8'd1);
    collect("basic", 3);
    check("basic_in_ready", {7'd0, ifc.in_ready}, 8'd1);
    check("basic_busy", {7'd0, busy}, 8'd0);

    send(8'h01, 3'd6, 4'd4);
    collect("wrap", 4);

    send(8'hA5, 3'd0, 4'd0);
    collect("count0", 8);

    send(8'h3C, 3'd5, 4'd12);
    collect("clamp", 8);

    send(8'h6B, 3'd3, 4'd1);
    collect("single", 1);

    // Backpressure with a competing request held on the input
    send(8'h5A, 3'd2, 4'd2);
    ifc.in_valid  = 1'b1;
    ifc.in_data   = 8'h12;
    ifc.in_first  = 3'd3;
    ifc.in_count  = 4'd1;
    ifc.out_ready = 1'b0;
    wait_valid();
    for (int k = 0; k < 5; k++) begin
      check_head("bp_hold");
      check("bp_in_ready", {7'd0, ifc.in_ready}, 8'd0);
      check("bp_valid", {7'd0, ifc.out_valid}, 8'd1);
      step();
    end
    ifc.out_ready = 1'b1;
    collect("bp", 2);
    check("bp_after_in_ready", {7'd0, ifc.in_ready}, 8'd1);
    step();
    ifc.in_valid = 1'b0;
    push_req(8'h12, 3'd3, 4'd1);
    collect("bp_next", 1);

    // Asynchronous reset while the second result is waiting
    send(8'h33, 3'd4, 4'd4);
    collect("pre_rst", 1);
    ifc.out_ready = 1'b0;
    wait_valid();
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    sb.delete();
    step();
    reset = 1'b0;
    ifc.out_ready = 1'b1;
    step();
    step();
    step();
    check("post_rst_no_valid", {7'd0, ifc.out_valid}, 8'd0);
    send(8'h81, 3'd7, 4'd2);
    collect("post_rst", 2);

    send(8'h07, 3'd0, 4'd2);
    collect("parity", 2);

    check("sb_drained", sb.size() == 0 ? 8'd1 : 8'd0, 8'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
